// File: rtl/mips_irq_pkg.sv
// mips_irq_pkg: shared constants for the interrupt request controller
package mips_irq_pkg;
  localparam int NUM_IRQ = 3;
  localparam int IRQ_L1 = 0;
  localparam int IRQ_L2 = 1;
  localparam int IRQ_L3 = 2;
  localparam int DEB_CYCLES_DEF = 16;
endpackage

// File: rtl/irq_debounce.sv
// irq_debounce: key synchronizer, debouncer and rise-pulse detector for one level
module irq_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic key,
  output logic rise
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic s1, s2, v1, v2, deb, armed, flip;
  logic [CW-1:0] cnt;
  assign flip = (s2 != deb) && (cnt == CW'(DEB_CYCLES - 1));
  // armed only after a genuine low is seen, so a key held through reset needs a re-press
  always_ff @(posedge clk)
    if (clr) {s1, s2, v1, v2, deb, armed, cnt, rise} <= '0;
    else begin
      s1 <= key;
      s2 <= s1;
      v1 <= 1'b1;
      v2 <= v1;
      armed <= armed | (v2 & ~s2);
      cnt <= (s2 != deb && !flip) ? cnt + 1'b1 : '0;
      deb <= deb ^ flip;
      rise <= flip & s2 & armed;
    end
endmodule

// File: rtl/int_request_ctrl.sv
// int_request_ctrl: debounced key interrupts with pending latch, priority masking and lost-request counters
module int_request_ctrl
  import mips_irq_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NUM_IRQ-1:0]       key_in,
  input  logic [NUM_IRQ-1:0]       running,
  output logic [NUM_IRQ-1:0]       irq,
  output logic [NUM_IRQ-1:0]       pending,
  output logic [NUM_IRQ*CNT_W-1:0] lost_cnt
);
  logic [NUM_IRQ-1:0] rise, run_q, run_rise;
  assign run_rise = running & ~run_q;
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_lvl
    logic [CNT_W-1:0] lost;
    irq_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk (clk),
      .clr (clr),
      .key (key_in[i]),
      .rise(rise[i])
    );
    always_ff @(posedge clk)
      if (clr) lost <= '0;
      else if (rise[i] && pending[i] && !run_rise[i] && lost != '1) lost <= lost + 1'b1;
    assign lost_cnt[i*CNT_W +: CNT_W] = lost;
  end
  // a new request wins over a simultaneous acknowledge
  always_ff @(posedge clk)
    if (clr) begin
      pending <= '0;
      run_q <= '0;
    end else begin
      pending <= rise | (pending & ~run_rise);
      run_q <= running;
    end
  always_comb begin
    irq = '0;
    irq[IRQ_L3] = pending[IRQ_L3];
    irq[IRQ_L2] = pending[IRQ_L2] & ~running[IRQ_L3];
    irq[IRQ_L1] = pending[IRQ_L1] & ~running[IRQ_L2] & ~running[IRQ_L3];
  end
endmodule

// File: tb/tb_int_request_ctrl.sv
// tb_int_request_ctrl: scoreboard and table driven bench for int_request_ctrl
module tb_int_request_ctrl;
  logic clk = 1'b0, clr = 1'b1;
  logic [2:0] key_in = '0, running = '0, irq, pending;
  logic [23:0] lost_cnt;
  int vectors = 0, miscompares = 0;

  typedef struct {
    string name;
    logic [2:0] pend;
    logic [2:0] irq;
    logic [23:0] lost;
  } exp_t;
  typedef struct {
    logic [2:0] run;
    logic [2:0] irq;
  } mask_vec_t;
  exp_t sb[$];
  mask_vec_t tbl[8];

  int_request_ctrl #(.DEB_CYCLES(16), .CNT_W(8)) dut (
    .clk(clk), .clr(clr), .key_in(key_in), .running(running),
    .irq(irq), .pending(pending), .lost_cnt(lost_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input string n, input logic [2:0] p, input logic [2:0] i, input logic [23:0] l);
    exp_t e;
    e.name = n;
    e.pend = p;
    e.irq = i;
    e.lost = l;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard: no expectation queued");
      return;
    end
    e = sb.pop_front();
    vectors++;
    if (pending !== e.pend || irq !== e.irq || lost_cnt !== e.lost) begin
      miscompares++;
      $display("FAIL %s: got pending=%b irq=%b lost=%h, want pending=%b irq=%b lost=%h",
               e.name, pending, irq, lost_cnt, e.pend, e.irq, e.lost);
    end
  endtask

  task automatic press(input int lvl);
    key_in[lvl] = 1'b1;
    tick(20);
    key_in[lvl] = 1'b0;
    tick(20);
  endtask

  task automatic ack(input logic [2:0] r);
    running = r;
    tick(1);
    running = '0;
  endtask

  initial begin
    tbl[0] = '{3'b000, 3'b111};
    tbl[1] = '{3'b001, 3'b111};
    tbl[2] = '{3'b010, 3'b110};
    tbl[3] = '{3'b011, 3'b110};
    tbl[4] = '{3'b100, 3'b100};
    tbl[5] = '{3'b101, 3'b100};
    tbl[6] = '{3'b110, 3'b100};
    tbl[7] = '{3'b111, 3'b100};

    expect_out("reset", 3'b000, 3'b000, 24'h0);
    tick(3);
    compare();
    clr = 1'b0;
    tick(3);

    key_in[0] = 1'b1;
    expect_out("lat18", 3'b000, 3'b000, 24'h0);
    tick(18);
    compare();
    expect_out("lat19", 3'b001, 3'b001, 24'h0);
    tick(1);
    compare();
    expect_out("ack_l1", 3'b000, 3'b000, 24'h0);
    ack(3'b001);
    compare();
    key_in = '0;
    tick(25);

    for (int k = 0; k < 20; k++) begin
      key_in[1] = ~key_in[1];
      tick(5);
    end
    expect_out("bounce", 3'b000, 3'b000, 24'h0);
    compare();
    tick(20);

    key_in = 3'b111;
    expect_out("press_all", 3'b111, 3'b111, 24'h0);
    tick(20);
    compare();
    key_in = '0;
    tick(20);
    for (int k = 0; k < 8; k++) begin
      running = tbl[k].run;
      expect_out($sformatf("mask_%0d", k), 3'b111, tbl[k].irq, 24'h0);
      #1 compare();
      running = '0;
      tick(1);
    end
    expect_out("clear_all", 3'b000, 3'b000, 24'h0);
    ack(3'b111);
    compare();
    tick(1);

    running = 3'b100;
    key_in[0] = 1'b1;
    expect_out("masked_l1", 3'b001, 3'b000, 24'h0);
    tick(20);
    compare();
    running = '0;
    key_in = '0;
    expect_out("unmask_l1", 3'b001, 3'b001, 24'h0);
    #1 compare();
    tick(1);
    expect_out("ack_masked", 3'b000, 3'b000, 24'h0);
    ack(3'b001);
    compare();
    tick(20);

    press(2);
    expect_out("l3_first", 3'b100, 3'b100, 24'h0);
    compare();
    for (int k = 0; k < 10; k++) press(2);
    expect_out("l3_lost10", 3'b100, 3'b100, 24'h0A0000);
    compare();
    for (int k = 0; k < 290; k++) press(2);
    expect_out("l3_sat", 3'b100, 3'b100, 24'hFF0000);
    compare();
    expect_out("l3_ack", 3'b000, 3'b000, 24'hFF0000);
    ack(3'b100);
    compare();
    tick(1);

    press(1);
    expect_out("l2_first", 3'b010, 3'b010, 24'hFF0000);
    compare();
    key_in[1] = 1'b1;
    tick(18);
    running[1] = 1'b1;
    expect_out("coincide", 3'b010, 3'b010, 24'hFF0000);
    tick(1);
    compare();
    running = '0;
    key_in = '0;
    tick(20);
    expect_out("l2_ack", 3'b000, 3'b000, 24'hFF0000);
    ack(3'b010);
    compare();
    tick(1);
    press(1);
    press(1);
    expect_out("l2_lost1", 3'b010, 3'b010, 24'hFF0100);
    compare();
    expect_out("l2_ack2", 3'b000, 3'b000, 24'hFF0100);
    ack(3'b010);
    compare();
    tick(1);

    key_in = 3'b001;
    tick(20);
    key_in = 3'b101;
    tick(10);
    clr = 1'b1;
    key_in = 3'b100;
    expect_out("clr_state", 3'b000, 3'b000, 24'h0);
    tick(2);
    compare();
    clr = 1'b0;
    expect_out("held_after_clr", 3'b000, 3'b000, 24'h0);
    tick(40);
    compare();
    key_in = '0;
    expect_out("released", 3'b000, 3'b000, 24'h0);
    tick(20);
    compare();
    key_in = 3'b100;
    expect_out("repress", 3'b100, 3'b100, 24'h0);
    tick(20);
    compare();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/int_request_ctrl.md
INT_REQUEST_CTRL -- requirements
Module: int_request_ctrl

Interface
REQ-001 The module SHALL have parameter DEB_CYCLES, default 16, meaning consecutive stable clk cycles required to accept a new key level.
REQ-002 The module SHALL have parameter CNT_W, default 8, meaning width of each lost-request counter.
REQ-003 The module SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The module SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-005 The module SHALL have port key_in  input  3  raw asynchronous interrupt buttons; bit0=level1, bit1=level2, bit2=level3.
REQ-006 The module SHALL have port running  input  3  CPU "servicing level n" flags; bit mapping as key_in.
REQ-007 The module SHALL have port irq  output  3  interrupt request lines to the CPU; bit mapping as key_in.
REQ-008 The module SHALL have port pending  output  3  latched, not-yet-acknowledged requests, for display.
REQ-009 The module SHALL have port lost_cnt  output  3*CNT_W  per-level count of requests dropped while that level was already pending; level1 in the LSBs.

Function
REQ-010 Each key_in bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Debounce: the debounced level SHALL change only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any mismatch-free cycle SHALL reset that bit's counter to 0.
REQ-012 A 0->1 transition of a debounced level SHALL produce a one-cycle rise pulse for that level.
REQ-013 Latency: key_in rising and held stable SHALL set pending[n] exactly 2+DEB_CYCLES+1 clk cycles later.
REQ-014 A rise pulse SHALL set pending[n]; a rising edge of running[n] (registered previous value 0, current value 1) SHALL clear pending[n].
REQ-015 Simultaneous rise pulse and running[n] rising edge on the same cycle SHALL leave pending[n]=1 (set wins).
REQ-016 A rise pulse while pending[n] is already 1 and running[n] is not rising SHALL increment lost_cnt[n], saturating at 2^CNT_W-1.
REQ-017 Priority masking (3 highest), combinational from registered state: irq[2]=pending[2]; irq[1]=pending[1] & ~running[2]; irq[0]=pending[0] & ~running[1] & ~running[2].
REQ-018 A masked request SHALL remain pending and appear on irq on the first cycle the mask condition is false.
REQ-019 irq and pending SHALL never glitch: all terms feeding them SHALL be flop outputs.
REQ-020 running SHALL be treated as synchronous to clk (the CPU clock is derived from clk by a register) and SHALL NOT be resynchronized.

Reset
REQ-021 While clr=1 at a clk edge: pending=0, irq=0, lost_cnt=0, debounced levels=0, debounce counters=0, synchronizer flops=0, running history=0.
REQ-022 A key held high through reset release SHALL NOT generate a request until it has been released and pressed again.
REQ-023 Reset asserted mid-debounce or while requests are pending SHALL discard all in-flight state without producing a pulse.

Structure
REQ-024 Package mips_irq_pkg SHALL hold NUM_IRQ=3, level index constants IRQ_L1=0, IRQ_L2=1, IRQ_L3=2, and default DEB_CYCLES.
REQ-025 Synchronizer, debounce counter and rise detector SHALL be one sub-module irq_debounce, instantiated NUM_IRQ times.
REQ-026 Pending, masking and lost-counter logic SHALL reside in int_request_ctrl.

Verification
REQ-027 DEB_CYCLES=16. Set key_in[0]=1 held → pending[0]=1 and irq[0]=1 at cycle 19; running[0] 0->1 → pending[0]=0 on the next cycle.
REQ-028 key_in[1] bounces 1/0 every 5 cycles for 100 cycles → pending stays 000 and lost_cnt stays 0.
REQ-029 running[2]=1; issue a key_in[0] press → pending[0]=1, irq[0]=0; drop running[2] → irq[0]=1 on the same cycle.
REQ-030 pending[2]=1; issue 300 further level-3 presses without ack → lost_cnt[2] saturates at 255 and pending[2] stays 1.
REQ-031 Rise pulse and running[1] edge coincide → pending[1]=1 and lost_cnt[1] unchanged; hold key_in[2]=1 across clr → no request until release and re-press.
